datapath_sequencer: RTL and testbench

Multi-cycle control unit for the 64-bit register-file / ALU / RAM datapath.
- Accepts one LEGv8 instruction at a time over a valid/ready handshake.
- Decodes it and drives the datapath control word (register selects, ALU function, immediate mux, tristate bus selects, RAM strobes) state by state.
- Sits between the instruction source (bench or future fetch unit) and the datapath.

---
 rtl/datapath_ctrl_pkg.sv | 45 ++++
 rtl/datapath_sequencer_if.sv | 28 ++
 rtl/datapath_sequencer_instr_decoder.sv | 43 ++++
 rtl/datapath_sequencer.sv | 139 +++++++++++++
 tb/tb_datapath_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_ctrl_pkg.sv
// Shared constants, state enum and control-word layout for the LEGv8 datapath sequencer.
package datapath_ctrl_pkg;
  localparam int DATA_W = 64;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] XZR = 5'd31;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_EXEC, S_LD_ADDR, S_LD_WB,
    S_ST_ADDR, S_ST_WR, S_DONE, S_ILLEGAL
  } state_t;

  typedef enum logic [2:0] {CL_R, CL_I, CL_LD, CL_ST, CL_BAD} iclass_t;

  typedef struct packed {
    logic [REG_AW-1:0] sa;
    logic [REG_AW-1:0] sb;
    logic [REG_AW-1:0] da;
    logic [4:0]        fs;
    logic              cin;
    logic              w;
    logic              selbork;
    logic [DATA_W-1:0] k;
    logic              tri_b2d;
    logic              tri_f2d;
    logic              tri_out2d;
    logic              tri_f2a;
    logic              wr_en;
    logic              rd_en;
  } ctrl_t;
endpackage

// File: rtl/datapath_sequencer_if.sv
// Instruction handshake plus datapath control word between source, sequencer and datapath.
interface datapath_sequencer_if;
  import datapath_ctrl_pkg::*;

  logic [31:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              done;
  logic              illegal;
  logic [REG_AW-1:0] SA, SB, DA;
  logic [4:0]        FS;
  logic              Cin, W, selbork;
  logic [DATA_W-1:0] k;
  logic              triSelBtoD, triSelFtoD, triSelOuttoD, triSelFtoA;
  logic              writeEn, readEn;

  modport master (
    output instr, instr_valid,
    input  instr_ready, done, illegal, SA, SB, DA, FS, Cin, W, selbork, k,
           triSelBtoD, triSelFtoD, triSelOuttoD, triSelFtoA, writeEn, readEn
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, done, illegal, SA, SB, DA, FS, Cin, W, selbork, k,
           triSelBtoD, triSelFtoD, triSelOuttoD, triSelFtoA, writeEn, readEn
  );
endinterface

// File: rtl/datapath_sequencer_instr_decoder.sv
// Combinational LEGv8 decode: instruction class, register fields, extended immediate, ALU op.
module instr_decoder
  import datapath_ctrl_pkg::*;
(
  input  logic [31:0]       instr,
  output iclass_t           iclass,
  output logic [REG_AW-1:0] rn,
  output logic [REG_AW-1:0] rm,
  output logic [REG_AW-1:0] rd,
  output logic [DATA_W-1:0] imm,
  output logic [4:0]        fs,
  output logic              cin
);
  always_comb begin
    iclass = CL_BAD;
    fs     = FS_ADD;
    cin    = 1'b0;
    imm    = '0;
    rn     = instr[9:5];
    rm     = instr[20:16];
    rd     = instr[4:0];
    case (instr[31:21])
      OP_ADD:  iclass = CL_R;
      OP_SUB:  begin iclass = CL_R; fs = FS_SUB; cin = 1'b1; end
      OP_AND:  begin iclass = CL_R; fs = FS_AND; end
      OP_ORR:  begin iclass = CL_R; fs = FS_ORR; end
      OP_LDUR: begin iclass = CL_LD; imm = {{(DATA_W-9){instr[20]}}, instr[20:12]}; end
      OP_STUR: begin iclass = CL_ST; imm = {{(DATA_W-9){instr[20]}}, instr[20:12]}; end
      default: ;
    endcase
    // 10-bit I-format opcodes do not alias any of the 11-bit ones above
    if (iclass == CL_BAD) begin
      case (instr[31:22])
        OP_ADDI: begin iclass = CL_I; imm = {{(DATA_W-12){1'b0}}, instr[21:10]}; end
        OP_SUBI: begin
          iclass = CL_I; fs = FS_SUB; cin = 1'b1;
          imm = {{(DATA_W-12){1'b0}}, instr[21:10]};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle LEGv8 control sequencer; outputs are registered from the next state.
// ILLEGAL_TRAP_EN: unsupported opcodes trap in ILLEGAL until reset instead of retiring as NOPs.
module datapath_sequencer
  import datapath_ctrl_pkg::*;
(
  input  logic clock,
  input  logic reset,
  datapath_sequencer_if.slave bus
);
  state_t            state, nxt;
  logic [31:0]       ir;
  ctrl_t             ctrl_q, ctrl_d;
  logic              rdy_q, rdy_d, done_q, done_d;
  logic              accept;
  iclass_t           iclass;
  logic [REG_AW-1:0] rn, rm, rd;
  logic [DATA_W-1:0] imm;
  logic [4:0]        fs;
  logic              cin;

  instr_decoder u_dec (
    .instr(ir), .iclass(iclass), .rn(rn), .rm(rm), .rd(rd),
    .imm(imm), .fs(fs), .cin(cin)
  );

  assign accept = (state == S_IDLE) && rdy_q && bus.instr_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      ir     <= '0;
      ctrl_q <= '0;
      rdy_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      ctrl_q <= ctrl_d;
      rdy_q  <= rdy_d;
      done_q <= done_d;
      if (accept) ir <= bus.instr;
    end
  end

  always_comb begin
    nxt    = state;
    ctrl_d = '0;
    rdy_d  = 1'b0;
    done_d = 1'b0;
    case (state)
      S_IDLE:    if (accept) nxt = S_DECODE;
      S_DECODE:
        case (iclass)
          CL_R, CL_I: nxt = S_EXEC;
          CL_LD:      nxt = S_LD_ADDR;
          CL_ST:      nxt = S_ST_ADDR;
`ifdef ILLEGAL_TRAP_EN
          default:    nxt = S_ILLEGAL;
`else
          default:    nxt = S_DONE;
`endif
        endcase
      S_EXEC:    nxt = S_DONE;
      S_LD_ADDR: nxt = S_LD_WB;
      S_LD_WB:   nxt = S_DONE;
      S_ST_ADDR: nxt = S_ST_WR;
      S_ST_WR:   nxt = S_DONE;
      S_DONE:    nxt = S_IDLE;
      S_ILLEGAL: nxt = S_ILLEGAL;
      default:   nxt = S_IDLE;
    endcase

    // Control word belongs to the state being entered so it lines up with it
    case (nxt)
      S_IDLE: rdy_d = 1'b1;
      S_DONE: done_d = 1'b1;
      S_EXEC: begin
        ctrl_d.sa      = rn;
        ctrl_d.sb      = rm;
        ctrl_d.da      = rd;
        ctrl_d.fs      = fs;
        ctrl_d.cin     = cin;
        ctrl_d.tri_f2d = 1'b1;
        ctrl_d.w       = (rd != XZR);
        if (iclass == CL_I) begin
          ctrl_d.selbork = 1'b1;
          ctrl_d.k       = imm;
        end
      end
      S_LD_ADDR, S_LD_WB, S_ST_ADDR, S_ST_WR: begin
        ctrl_d.sa      = rn;
        ctrl_d.selbork = 1'b1;
        ctrl_d.k       = imm;
        ctrl_d.fs      = FS_ADD;
        ctrl_d.tri_f2a = 1'b1;
        if (nxt == S_LD_ADDR || nxt == S_LD_WB) begin
          ctrl_d.rd_en = 1'b1;
        end else begin
          ctrl_d.sb      = rd;
          ctrl_d.tri_b2d = 1'b1;
        end
        if (nxt == S_LD_WB) begin
          ctrl_d.tri_out2d = 1'b1;
          ctrl_d.da        = rd;
          ctrl_d.w         = (rd != XZR);
        end
        if (nxt == S_ST_WR) ctrl_d.wr_en = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic ill_q;
  always_ff @(posedge clock) begin
    if (reset) ill_q <= 1'b0;
    else       ill_q <= (nxt == S_ILLEGAL);
  end
  assign bus.illegal = ill_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.instr_ready  = rdy_q;
  assign bus.done         = done_q;
  assign bus.SA           = ctrl_q.sa;
  assign bus.SB           = ctrl_q.sb;
  assign bus.DA           = ctrl_q.da;
  assign bus.FS           = ctrl_q.fs;
  assign bus.Cin          = ctrl_q.cin;
  assign bus.W            = ctrl_q.w;
  assign bus.selbork      = ctrl_q.selbork;
  assign bus.k            = ctrl_q.k;
  assign bus.triSelBtoD   = ctrl_q.tri_b2d;
  assign bus.triSelFtoD   = ctrl_q.tri_f2d;
  assign bus.triSelOuttoD = ctrl_q.tri_out2d;
  assign bus.triSelFtoA   = ctrl_q.tri_f2a;
  assign bus.writeEn      = ctrl_q.wr_en;
  assign bus.readEn       = ctrl_q.rd_en;
endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: spec-constant vector table, hand corner sequences, random vs trace model.
module tb_datapath_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  datapath_sequencer_if bus ();
  datapath_sequencer dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [4:0]  sa, sb, da, fs;
    logic        cin, w, selbork;
    logic [63:0] k;
    logic        b2d, f2d, out2d, f2a, wen, ren, rdy, done, ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    int          key;
    int          lat;
    exp_t        ex;
  } vec_t;

  int   ntot = 0, npass = 0;
  exp_t trq[$];
  vec_t tv[12];

  function automatic exp_t act();
    exp_t a;
    a.sa = bus.SA; a.sb = bus.SB; a.da = bus.DA; a.fs = bus.FS;
    a.cin = bus.Cin; a.w = bus.W; a.selbork = bus.selbork; a.k = bus.k;
    a.b2d = bus.triSelBtoD; a.f2d = bus.triSelFtoD; a.out2d = bus.triSelOuttoD;
    a.f2a = bus.triSelFtoA; a.wen = bus.writeEn; a.ren = bus.readEn;
    a.rdy = bus.instr_ready; a.done = bus.done; a.ill = bus.illegal;
    return a;
  endfunction

  function automatic exp_t mk(int sa, int sb, int da, int fs, bit cin, bit w, bit sel,
                              logic [63:0] k, bit b2d, bit f2d, bit out2d, bit f2a,
                              bit wen, bit ren);
    exp_t e = '0;
    e.sa = 5'(sa); e.sb = 5'(sb); e.da = 5'(da); e.fs = 5'(fs);
    e.cin = cin; e.w = w; e.selbork = sel; e.k = k;
    e.b2d = b2d; e.f2d = f2d; e.out2d = out2d; e.f2a = f2a; e.wen = wen; e.ren = ren;
    return e;
  endfunction

  function automatic exp_t idle_e();
    exp_t e = '0;
    e.rdy = 1'b1;
    return e;
  endfunction

  function automatic exp_t done_e();
    exp_t e = '0;
    e.done = 1'b1;
    return e;
  endfunction

  task automatic chk(input string nm, input exp_t e);
    exp_t a;
    a = act();
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s: got %h want %h", nm, a, e);
    ntot++;
    if (int'(a.b2d) + int'(a.f2d) + int'(a.out2d) <= 1 && !(a.ren && a.wen) && !(a.w && a.wen))
      npass++;
    else $display("FAIL %s invariant: b2d/f2d/out2d %b%b%b ren %b wen %b w %b want exclusive",
                  nm, a.b2d, a.f2d, a.out2d, a.ren, a.wen, a.w);
  endtask

  // Expected per-cycle outputs after the accept edge, straight from the opcode table.
  task automatic build(input logic [31:0] ins);
    logic [10:0] op11;
    logic [9:0]  op10;
    logic [8:0]  a9;
    int          rd, rn, rm, fs, kind;
    exp_t        e;
    op11 = ins[31:21]; op10 = ins[31:22]; a9 = ins[20:12];
    rd = int'(ins[4:0]); rn = int'(ins[9:5]); rm = int'(ins[20:16]);
    kind = 4; fs = 8;
    if      (op11 == 11'b10001011000) kind = 0;
    else if (op11 == 11'b11001011000) begin kind = 0; fs = 9; end
    else if (op11 == 11'b10001010000) begin kind = 0; fs = 0; end
    else if (op11 == 11'b10101010000) begin kind = 0; fs = 4; end
    else if (op10 == 10'b1001000100)  kind = 1;
    else if (op10 == 10'b1101000100)  begin kind = 1; fs = 9; end
    else if (op11 == 11'b11111000010) kind = 2;
    else if (op11 == 11'b11111000000) kind = 3;
    trq.delete();
    trq.push_back('0);
    if (kind <= 1) begin
      e = mk(rn, rm, rd, fs, fs == 9, rd != 31, kind == 1,
             kind == 1 ? 64'(ins[21:10]) : 64'd0, 0, 1, 0, 0, 0, 0);
      trq.push_back(e);
      trq.push_back(done_e());
    end else if (kind <= 3) begin
      e = mk(rn, 0, 0, 8, 0, 0, 1, (a9 >= 9'd256) ? 64'(a9) - 64'd512 : 64'(a9),
             0, 0, 0, 1, 0, kind == 2);
      if (kind == 3) begin e.sb = 5'(rd); e.b2d = 1'b1; end
      trq.push_back(e);
      if (kind == 2) begin e.out2d = 1'b1; e.w = (rd != 31); e.da = 5'(rd); end
      else e.wen = 1'b1;
      trq.push_back(e);
      trq.push_back(done_e());
    end else begin
`ifdef ILLEGAL_TRAP_EN
      e = '0; e.ill = 1'b1;
      repeat (3) trq.push_back(e);
`else
      trq.push_back(done_e());
`endif
    end
  endtask

  task automatic accept(input logic [31:0] ins, output bit ok);
    int t = 0;
    while (bus.instr_ready !== 1'b1 && t < 20) begin @(negedge clock); t++; end
    ntot++;
    if (bus.instr_ready === 1'b1) begin
      npass++; ok = 1'b1;
      bus.instr = ins; bus.instr_valid = 1'b1;
      @(negedge clock);
    end else begin
      ok = 1'b0;
      $display("FAIL accept %h: instr_ready %b want 1 within 20 cycles", ins, bus.instr_ready);
    end
  endtask

  // Busy cycles get junk on instr/instr_valid; valid drops before the cycle that returns to IDLE.
  task automatic junk(input bit last);
    if (last) bus.instr_valid = 1'b0;
    else begin bus.instr = $urandom; bus.instr_valid = 1'($urandom_range(0, 1)); end
  endtask

  task automatic issue(input logic [31:0] ins, input string nm);
    bit ok;
    build(ins);
    accept(ins, ok);
    if (!ok) return;
    for (int i = 0; i < trq.size(); i++) begin
      chk($sformatf("%s %h c%0d", nm, ins, i + 1), trq[i]);
      junk(i == trq.size() - 1);
      @(negedge clock);
    end
    if (trq[trq.size()-1].done) chk($sformatf("%s %h idle", nm, ins), idle_e());
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          s;
    r = $urandom;
`ifdef ILLEGAL_TRAP_EN
    s = $urandom_range(0, 7);
`else
    s = $urandom_range(0, 8);
`endif
    case (s)
      0: return {11'b10001011000, r[20:0]};
      1: return {11'b11001011000, r[20:0]};
      2: return {11'b10001010000, r[20:0]};
      3: return {11'b10101010000, r[20:0]};
      4: return {10'b1001000100, r[21:0]};
      5: return {10'b1101000100, r[21:0]};
      6: return {11'b11111000010, r[20:0]};
      7: return {11'b11111000000, r[20:0]};
      default: return {11'b0, r[20:0]};
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    tv[0]  = '{32'h8B020023, 2, 3, mk(1, 2, 3, 8, 0, 1, 0, 64'd0, 0, 1, 0, 0, 0, 0)};
    tv[1]  = '{32'hD1002885, 2, 3, mk(4, 0, 5, 9, 1, 1, 1, 64'd10, 0, 1, 0, 0, 0, 0)};
    tv[2]  = '{32'hF85F8047, 2, 4, mk(2, 0, 0, 8, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 1, 0, 1)};
    tv[3]  = '{32'hF85F8047, 3, 4, mk(2, 0, 7, 8, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 1, 1, 0, 1)};
    tv[4]  = '{32'hF8010026, 2, 4, mk(1, 6, 0, 8, 0, 0, 1, 64'd16, 1, 0, 0, 1, 0, 0)};
    tv[5]  = '{32'hF8010026, 3, 4, mk(1, 6, 0, 8, 0, 0, 1, 64'd16, 1, 0, 0, 1, 1, 0)};
    tv[6]  = '{32'h8B02003F, 2, 3, mk(1, 2, 31, 8, 0, 0, 0, 64'd0, 0, 1, 0, 0, 0, 0)};
    tv[7]  = '{32'h8A0B0149, 2, 3, mk(10, 11, 9, 0, 0, 1, 0, 64'd0, 0, 1, 0, 0, 0, 0)};
    tv[8]  = '{32'hAA0600A4, 2, 3, mk(5, 6, 4, 4, 0, 1, 0, 64'd0, 0, 1, 0, 0, 0, 0)};
    tv[9]  = '{32'hCB030041, 2, 3, mk(2, 3, 1, 9, 1, 1, 0, 64'd0, 0, 1, 0, 0, 0, 0)};
    tv[10] = '{32'h913FFC62, 2, 3, mk(3, 31, 2, 8, 0, 1, 1, 64'd4095, 0, 1, 0, 0, 0, 0)};
    tv[11] = '{32'hF84FF01F, 3, 4, mk(0, 0, 31, 8, 0, 0, 1, 64'd255, 0, 0, 1, 1, 0, 1)};

    // Reset with an ADD already offered: nothing may be accepted or driven.
    bus.instr = 32'h8B020023; bus.instr_valid = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset", '0);
    reset = 1'b0;
    @(negedge clock);

    foreach (tv[t]) begin
      accept(tv[t].ins, ok);
      if (!ok) continue;
      for (int c = 1; c <= tv[t].lat; c++) begin
        if (c == tv[t].key) chk($sformatf("vec%0d key", t), tv[t].ex);
        if (c == tv[t].lat) chk($sformatf("vec%0d done", t), done_e());
        junk(c == tv[t].lat);
        @(negedge clock);
      end
    end
    chk("after table idle", idle_e());

    // Back-to-back XZR write with valid held: second accept only after DONE.
    build(32'h8B02003F);
    bus.instr = 32'h8B02003F; bus.instr_valid = 1'b1;
    @(negedge clock);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < trq.size(); i++) begin
        chk($sformatf("b2b%0d c%0d", r, i + 1), trq[i]);
        if (r == 1 && i == trq.size() - 1) bus.instr_valid = 1'b0;
        @(negedge clock);
      end
      if (r == 0) begin chk("b2b idle", idle_e()); @(negedge clock); end
    end
    chk("b2b end idle", idle_e());

    // Unsupported opcode, then reset to recover either way.
    issue(32'h0000_0000, "illegal");
    reset = 1'b1; bus.instr_valid = 1'b0;
    @(negedge clock);
    chk("reset after illegal", '0);
    reset = 1'b0;
    @(negedge clock);
    chk("release after illegal", idle_e());

    // Reset landing in LD_WB abandons the load without a done pulse.
    build(32'hF85F8047);
    accept(32'hF85F8047, ok);
    if (ok) begin
      bus.instr_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("ld mid c%0d", i + 1), trq[i]);
        if (i < 2) @(negedge clock);
      end
      reset = 1'b1;
      @(negedge clock);
      chk("reset mid load", '0);
      reset = 1'b0;
      @(negedge clock);
      chk("release mid load", idle_e());
    end

    for (int n = 0; n < 40; n++) issue(rand_instr(), "rand");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
